// File: rtl/audio_sample_pacer.sv
// Purpose: paces multi-channel audio frames to a fractional-N sample rate derived from one clock.
// Latency: a frame pushed into an empty FIFO appears on out_data at the first sample tick after the push cycle.
// Backpressure: in_ready drops while the FIFO holds DEPTH frames; on a tick with an empty FIFO, underrun pulses.
// Optional statistics outputs (underrun_count, overflow_count) are built when AUDIO_PACER_STATS_EN is defined.
module audio_sample_pacer #(
    parameter int WIDTH         = 24,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ACC_WIDTH-1:0]          rate_inc,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CHANNELS*WIDTH-1:0]     out_data,
    output logic                          sample_tick,
    output logic                          audio_clk,
    output logic [$clog2(DEPTH):0]        fill,
    output logic                          underrun
`ifdef AUDIO_PACER_STATS_EN
    ,
    output logic [15:0]                   underrun_count,
    output logic [15:0]                   overflow_count
`endif
);

    localparam int FW = CHANNELS * WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // The pointer arithmetic below relies on natural wrap, so DEPTH must be a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("audio_sample_pacer: DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // Phase accumulator: the carry out of the add is the sample tick.
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 tick;

    assign acc_sum  = {1'b0, acc} + {1'b0, rate_inc};
    assign acc_next = acc_sum[ACC_WIDTH-1:0];
    assign tick     = acc_sum[ACC_WIDTH];

    // Advance the phase every clock; audio_clk is the registered MSB so it falls on the carry.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            audio_clk <= 1'b0;
        end else begin
            acc       <= acc_next;
            audio_clk <= acc_next[ACC_WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [FW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_vld;
    logic          pop_vld;
    logic          fifo_empty;

    // Full is judged on the registered fill only, so a pop in the same cycle never frees a slot early.
    assign in_ready   = (fill != CW'(DEPTH));
    assign fifo_empty = (fill == '0);
    assign push_vld   = in_valid && in_ready;
    assign pop_vld    = tick && !fifo_empty;

    // Frame storage; contents need no reset because fill gates every read.
    always_ff @(posedge clock) begin
        if (push_vld) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves fill unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output stage: frame, strobe and underrun all update on the tick edge.
    // ------------------------------------------------------------------
    // A frame pushed on an underrun tick is only stored; it is presented on the following tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data    <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= tick;
            underrun    <= tick && fifo_empty;
            if (pop_vld) begin
                out_data <= mem[rd_ptr];
            end else if (tick && (UNDERRUN_ZERO != 0)) begin
                out_data <= '0;
            end
        end
    end

`ifdef AUDIO_PACER_STATS_EN
    // Saturating event counters for starved ticks and refused producer frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            underrun_count <= '0;
            overflow_count <= '0;
        end else begin
            if (tick && fifo_empty && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
            if (in_valid && !in_ready && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: a hold-policy and a zero-policy instance share all inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Stats outputs are checked only when AUDIO_PACER_STATS_EN is defined.
module tb_audio_sample_pacer;

    localparam int FW = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   rate_inc = '0;
    logic [FW-1:0] in_data = '0;
    logic          in_valid = 1'b0;

    logic          in_ready, sample_tick, audio_clk, underrun;
    logic [FW-1:0] out_data;
    logic [3:0]    fill;
    logic          z_in_ready, z_sample_tick, z_audio_clk, z_underrun;
    logic [FW-1:0] z_out_data;
    logic [3:0]    z_fill;
`ifdef AUDIO_PACER_STATS_EN
    logic [15:0]   underrun_count, overflow_count, z_underrun_count, z_overflow_count;
`endif

    audio_sample_pacer #(.WIDTH(24), .CHANNELS(2), .DEPTH(8), .ACC_WIDTH(32), .UNDERRUN_ZERO(0)) dut (
        .clock(clock), .reset(reset), .rate_inc(rate_inc), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .sample_tick(sample_tick), .audio_clk(audio_clk),
        .fill(fill), .underrun(underrun)
`ifdef AUDIO_PACER_STATS_EN
        , .underrun_count(underrun_count), .overflow_count(overflow_count)
`endif
    );

    audio_sample_pacer #(.WIDTH(24), .CHANNELS(2), .DEPTH(8), .ACC_WIDTH(32), .UNDERRUN_ZERO(1)) dut_z (
        .clock(clock), .reset(reset), .rate_inc(rate_inc), .in_data(in_data), .in_valid(in_valid),
        .in_ready(z_in_ready), .out_data(z_out_data), .sample_tick(z_sample_tick), .audio_clk(z_audio_clk),
        .fill(z_fill), .underrun(z_underrun)
`ifdef AUDIO_PACER_STATS_EN
        , .underrun_count(z_underrun_count), .overflow_count(z_overflow_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          vld;
        logic [FW-1:0] dat;
        int            exp_fill;
        logic          exp_rdy;
    } vec_t;

    vec_t          tbl [11];
    logic [FW-1:0] frames [8];
    int            total = 0;
    int            bad = 0;
    bit            last_push = 1'b0;
    bit            feed = 1'b0;
    int            seq = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One clock: remember whether the producer frame was accepted, then advance the feed if enabled.
    task automatic step();
        last_push = in_valid && in_ready;
        @(posedge clock);
        #1;
        if (feed && last_push) begin
            seq++;
            in_data = FW'(seq);
        end
    endtask

    task automatic wait_tick(input int maxc, input string nm, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < maxc) begin
            step();
            n++;
            got = sample_tick;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no sample_tick within %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        int            n, hi, span, min_n, max_n, min_hi, max_hi, nund, nbreak, tmo;
        logic [FW-1:0] prev;
        logic [FW-1:0] frame_b;

        for (int i = 0; i < 8; i++) frames[i] = {24'(32'hA00000 + i), 24'(32'h500000 + i)};
        frames[7] = 48'h123456_654321;
        frame_b   = 48'hB0B0B0_0B0B0B;

        // Fill/full vectors: rate 0, ten back-to-back pushes, then one idle cycle.
        tbl[0]  = '{1'b1, frames[0], 1, 1'b1};
        tbl[1]  = '{1'b1, frames[1], 2, 1'b1};
        tbl[2]  = '{1'b1, frames[2], 3, 1'b1};
        tbl[3]  = '{1'b1, frames[3], 4, 1'b1};
        tbl[4]  = '{1'b1, frames[4], 5, 1'b1};
        tbl[5]  = '{1'b1, frames[5], 6, 1'b1};
        tbl[6]  = '{1'b1, frames[6], 7, 1'b1};
        tbl[7]  = '{1'b1, frames[7], 8, 1'b0};
        tbl[8]  = '{1'b1, 48'hDEAD00_000008, 8, 1'b0};
        tbl[9]  = '{1'b1, 48'hDEAD00_000009, 8, 1'b0};
        tbl[10] = '{1'b0, 48'h0, 8, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_fill", fill, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_sample_tick", sample_tick, 0);
        chk("rst_audio_clk", audio_clk, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b0;

        // Fill to full with no ticks
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].vld;
            in_data  = tbl[i].dat;
            step();
            chk($sformatf("tbl%0d_fill", i), fill, tbl[i].exp_fill);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_no_tick", i), sample_tick, 0);
        end
`ifdef AUDIO_PACER_STATS_EN
        chk("overflow_count", overflow_count, 2);
`endif

        // Order: four-cycle tick period, frames leave in push order
        rate_inc = 32'h4000_0000;
        for (int k = 0; k < 8; k++) begin
            wait_tick(10, "order_wait", n);
            chk($sformatf("order%0d_gap", k), n, 4);
            chk($sformatf("order%0d_data", k), out_data, frames[k]);
            chk($sformatf("order%0d_zdata", k), z_out_data, frames[k]);
            chk($sformatf("order%0d_underrun", k), underrun, 0);
            chk($sformatf("order%0d_fill", k), fill, 7 - k);
        end

        // Underrun: hold vs zero policy
        wait_tick(10, "underrun_wait", n);
        chk("underrun_gap", n, 4);
        chk("underrun_hold_data", out_data, 48'h123456_654321);
        chk("underrun_zero_data", z_out_data, 0);
        chk("underrun_pulse", underrun, 1);
        chk("underrun_pulse_z", z_underrun, 1);
`ifdef AUDIO_PACER_STATS_EN
        chk("underrun_count_1", underrun_count, 1);
        chk("underrun_count_1z", z_underrun_count, 1);
`endif
        step();
        chk("underrun_one_cycle", underrun, 0);
        chk("tick_one_cycle", sample_tick, 0);

        // Push in the same cycle as an underrun tick
        step();
        step();
        in_valid = 1'b1;
        in_data  = frame_b;
        step();
        in_valid = 1'b0;
        chk("push_ur_tick", sample_tick, 1);
        chk("push_ur_underrun", underrun, 1);
        chk("push_ur_fill", fill, 1);
        chk("push_ur_hold", out_data, 48'h123456_654321);
        wait_tick(10, "push_ur_next", n);
        chk("push_ur_next_gap", n, 4);
        chk("push_ur_next_data", out_data, frame_b);
        chk("push_ur_next_underrun", underrun, 0);
        chk("push_ur_next_fill", fill, 0);
`ifdef AUDIO_PACER_STATS_EN
        chk("underrun_count_2", underrun_count, 2);
`endif

        // 48 kHz at 30 MHz with the FIFO kept topped up
        rate_inc = 32'd6871948;
        seq      = 1000;
        in_data  = FW'(seq);
        in_valid = 1'b1;
        feed     = 1'b1;
        wait_tick(700, "rate_sync", n);
        chk("rate_sync_underrun", underrun, 0);
        prev   = out_data;
        span   = 0;
        min_n  = 1 << 30;
        max_n  = 0;
        min_hi = 1 << 30;
        max_hi = 0;
        nund   = 0;
        nbreak = 0;
        tmo    = 0;
        for (int k = 0; k < 100; k++) begin
            bit got;
            got = 1'b0;
            n   = 0;
            hi  = 0;
            while (!got && n < 700) begin
                step();
                n++;
                if (audio_clk) hi++;
                if (underrun) nund++;
                got = sample_tick;
            end
            if (!got) tmo++;
            span += n;
            if (n < min_n) min_n = n;
            if (n > max_n) max_n = n;
            if (hi < min_hi) min_hi = hi;
            if (hi > max_hi) max_hi = hi;
            if (out_data != prev + FW'(1)) nbreak++;
            prev = out_data;
        end
        feed     = 1'b0;
        in_valid = 1'b0;
        chk("rate_timeouts", tmo, 0);
        chk_rng("rate_min_interval", min_n, 624, 626);
        chk_rng("rate_max_interval", max_n, 624, 626);
        chk_rng("rate_span_100", span, 62499, 62501);
        chk_rng("duty_min_high", min_hi, 311, 314);
        chk_rng("duty_max_high", max_hi, 311, 314);
        chk("rate_no_underrun", nund, 0);
        chk("rate_sequence_breaks", nbreak, 0);
        chk("full_pop_refuses_push", fill, 7);

        // Reset mid-stream with five frames held
        rate_inc = 32'h4000_0000;
        wait_tick(10, "drain1", n);
        wait_tick(10, "drain2", n);
        chk("pre_reset_fill", fill, 5);
        n = 0;
        while (!audio_clk && n < 4) begin
            step();
            n++;
        end
        chk("pre_reset_audio_clk", audio_clk, 1);
        chk("pre_reset_out_nonzero", (out_data != '0), 1);
        reset    = 1'b1;
        rate_inc = 32'h1000_0000;
        step();
        chk("mid_rst_fill", fill, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_audio_clk", audio_clk, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_no_tick", sample_tick, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_z_fill", z_fill, 0);
        chk("mid_rst_z_out", z_out_data, 0);
        chk("mid_rst_z_audio_clk", z_audio_clk, 0);
        chk("mid_rst_z_in_ready", z_in_ready, 1);
        chk("mid_rst_z_tick", z_sample_tick, 0);
        chk("mid_rst_z_underrun", z_underrun, 0);
`ifdef AUDIO_PACER_STATS_EN
        chk("mid_rst_underrun_count", underrun_count, 0);
        chk("mid_rst_overflow_count", overflow_count, 0);
        chk("mid_rst_z_counts", {z_underrun_count, z_overflow_count}, 0);
`endif
        reset = 1'b0;
        wait_tick(40, "post_rst_tick", n);
        chk("post_rst_first_tick", n, 16);
        chk("post_rst_underrun", underrun, 1);
        chk("post_rst_out_data", out_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
